teclado_atm: RTL and testbench

Keypad front-end for the ATM controller: sits directly upstream of `controlador` and turns raw, bouncing key presses into the `DIGITO`/`DIGITO_STB` stream used for PIN entry and the `MONTO`/`MONTO_STB` value used for withdrawals and deposits. Digit keys are debounced, decoded and, in amount mode, accumulated in decimal into a 32-bit binary amount. The amount is released on ENTER.

---
 rtl/teclado_pkg.sv | 25 ++
 rtl/teclado_atm_if.sv | 30 +++
 rtl/teclado_antirrebote.sv | 132 +++++++++++++
 rtl/teclado_atm.sv | 123 ++++++++++++
 tb/tb_teclado_atm.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// ---------------------------------------------------------------------------
// teclado_pkg
// Shared definitions for the ATM keypad front-end.
//   - TECLA_ENTER / TECLA_BORRAR : control key codes
//   - ANCHO_MONTO                : width of the committed amount
//   - estado_t                   : debounce FSM states
//   - es_digito()                : true for key codes 0-9
// ---------------------------------------------------------------------------
package teclado_pkg;

    localparam logic [3:0] TECLA_ENTER  = 4'hA;
    localparam logic [3:0] TECLA_BORRAR = 4'hB;
    localparam int         ANCHO_MONTO  = 32;

    typedef enum logic [1:0] {
        REPOSO,
        PRESIONANDO,
        SOLTANDO
    } estado_t;

    function automatic logic es_digito(input logic [3:0] c);
        return (c <= 4'd9);
    endfunction

endpackage

// File: rtl/teclado_atm_if.sv
// ---------------------------------------------------------------------------
// teclado_atm_if
// Keypad <-> front-end signal bundle.
//   master : key source / controller side (drives TECLA, TECLA_VALIDA,
//            MODO_MONTO; receives DIGITO/MONTO streams and DESBORDE)
//   slave  : teclado_atm side
// ---------------------------------------------------------------------------
interface teclado_atm_if;
    import teclado_pkg::*;

    logic [3:0]             TECLA;
    logic                   TECLA_VALIDA;
    logic                   MODO_MONTO;
    logic [3:0]             DIGITO;
    logic                   DIGITO_STB;
    logic [ANCHO_MONTO-1:0] MONTO;
    logic                   MONTO_STB;
    logic                   DESBORDE;

    modport master (
        output TECLA, TECLA_VALIDA, MODO_MONTO,
        input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
    );

    modport slave (
        input  TECLA, TECLA_VALIDA, MODO_MONTO,
        output DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
    );

endinterface

// File: rtl/teclado_antirrebote.sv
// ---------------------------------------------------------------------------
// teclado_antirrebote
// Turns the raw key-down level into a single key event per press.
// Build option: TECLADO_DEBOUNCE_EN
//   defined     : REPOSO/PRESIONANDO/SOLTANDO FSM, DEBOUNCE_CYCLES stable
//                 samples required for both press and release.
//   not defined : input treated as clean; event on sampled 0->1 edge.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   tecla         : raw key code
//   tecla_valida  : raw key-down level
//   evento        : one-cycle key event (valid during the sampling cycle,
//                   so the consumer registers it on the accepting edge)
//   codigo        : key code belonging to evento
// ---------------------------------------------------------------------------
module teclado_antirrebote
    import teclado_pkg::*;
`ifdef TECLADO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    output logic       evento,
    output logic [3:0] codigo
);

`ifdef TECLADO_DEBOUNCE_EN

    localparam logic [7:0] N = 8'(DEBOUNCE_CYCLES);

    estado_t    estado;
    logic [7:0] cnt;
    logic [3:0] cod_q;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt + 8'd1;

    // The event is decoded from the current sample so that the consumer's
    // registers update on the same edge that completes the count.
    always_comb begin
        evento = 1'b0;
        codigo = cod_q;
        case (estado)
            REPOSO: begin
                codigo = tecla;
                if (tecla_valida && N == 8'd1)
                    evento = 1'b1;
            end
            PRESIONANDO: begin
                if (tecla_valida && tecla == cod_q && cnt_inc == N)
                    evento = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset lands in SOLTANDO so a key held through reset must be released
    // for N samples before it can be accepted again.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= SOLTANDO;
            cnt    <= 8'd0;
            cod_q  <= 4'd0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (tecla_valida) begin
                        cod_q <= tecla;
                        if (N == 8'd1) begin
                            estado <= SOLTANDO;
                            cnt    <= 8'd0;
                        end else begin
                            estado <= PRESIONANDO;
                            cnt    <= 8'd1;
                        end
                    end
                end
                PRESIONANDO: begin
                    if (!tecla_valida) begin
                        estado <= REPOSO;
                        cnt    <= 8'd0;
                    end else if (tecla != cod_q) begin
                        cod_q <= tecla;
                        cnt   <= 8'd1;
                    end else if (cnt_inc == N) begin
                        estado <= SOLTANDO;
                        cnt    <= 8'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SOLTANDO: begin
                    if (tecla_valida) begin
                        cnt <= 8'd0;
                    end else if (cnt_inc == N) begin
                        estado <= REPOSO;
                        cnt    <= 8'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    estado <= SOLTANDO;
                    cnt    <= 8'd0;
                end
            endcase
        end
    end

`else

    // prev resets high: a key held through reset needs one low sample first.
    logic prev;

    always_ff @(posedge clock) begin
        if (reset)
            prev <= 1'b1;
        else
            prev <= tecla_valida;
    end

    assign evento = tecla_valida & ~prev;
    assign codigo = tecla;

`endif

endmodule

// File: rtl/teclado_atm.sv
// ---------------------------------------------------------------------------
// teclado_atm
// Keypad front-end for the ATM controller: debounced key events are decoded
// into a PIN digit stream (MODO_MONTO=0) or accumulated in decimal into a
// 32-bit amount released on ENTER (MODO_MONTO=1).
// Build option: TECLADO_DEBOUNCE_EN (see teclado_antirrebote).
// Parameters:
//   DEBOUNCE_CYCLES : stable samples per press/release (1-255, debounce build)
//   MAX_DIGITS      : decimal digits accepted per amount
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : teclado_atm_if.slave (TECLA/TECLA_VALIDA/MODO_MONTO in,
//                  DIGITO/DIGITO_STB/MONTO/MONTO_STB/DESBORDE out)
// ---------------------------------------------------------------------------
module teclado_atm
    import teclado_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 10
) (
    input  logic          clock,
    input  logic          reset,
    teclado_atm_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic                   evento;
    logic [3:0]             codigo;

    logic [ANCHO_MONTO-1:0] acc, acc_base, acc_n;
    logic [CNT_W-1:0]       cnt, cnt_base, cnt_n;
    logic                   modo_q;
    logic [3:0]             digito, digito_n;
    logic                   dstb_n, mstb_n, desb_n;
    logic                   dstb, mstb, desb;
    logic [ANCHO_MONTO-1:0] monto, monto_n;
    logic [35:0]            cand;

`ifdef TECLADO_DEBOUNCE_EN
    teclado_antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
`else
    teclado_antirrebote u_antirrebote (
`endif
        .clock        (clock),
        .reset        (reset),
        .tecla        (bus.TECLA),
        .tecla_valida (bus.TECLA_VALIDA),
        .evento       (evento),
        .codigo       (codigo)
    );

    always_comb begin
        // A mode change wipes the amount in the same cycle; a coincident key
        // event already sees the cleared accumulator.
        acc_base = (bus.MODO_MONTO != modo_q) ? '0 : acc;
        cnt_base = (bus.MODO_MONTO != modo_q) ? '0 : cnt;
        cand     = 36'(acc_base) * 36'd10 + 36'(codigo);

        acc_n    = acc_base;
        cnt_n    = cnt_base;
        monto_n  = monto;
        digito_n = digito;
        dstb_n   = 1'b0;
        mstb_n   = 1'b0;
        desb_n   = 1'b0;

        if (evento) begin
            if (!bus.MODO_MONTO) begin
                if (es_digito(codigo)) begin
                    digito_n = codigo;
                    dstb_n   = 1'b1;
                end
            end else if (es_digito(codigo)) begin
                if (cand > 36'h0_FFFF_FFFF || cnt_base == CNT_W'(MAX_DIGITS)) begin
                    desb_n = 1'b1;
                end else begin
                    acc_n = cand[ANCHO_MONTO-1:0];
                    cnt_n = cnt_base + CNT_W'(1);
                end
            end else if (codigo == TECLA_ENTER) begin
                if (cnt_base != '0) begin
                    monto_n = acc_base;
                    mstb_n  = 1'b1;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            end else if (codigo == TECLA_BORRAR) begin
                acc_n = '0;
                cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            modo_q <= 1'b0;
            digito <= 4'd0;
            monto  <= '0;
            dstb   <= 1'b0;
            mstb   <= 1'b0;
            desb   <= 1'b0;
        end else begin
            acc    <= acc_n;
            cnt    <= cnt_n;
            modo_q <= bus.MODO_MONTO;
            digito <= digito_n;
            monto  <= monto_n;
            dstb   <= dstb_n;
            mstb   <= mstb_n;
            desb   <= desb_n;
        end
    end

    assign bus.DIGITO     = digito;
    assign bus.DIGITO_STB = dstb;
    assign bus.MONTO      = monto;
    assign bus.MONTO_STB  = mstb;
    assign bus.DESBORDE   = desb;

endmodule

// File: tb/tb_teclado_atm.sv
// ---------------------------------------------------------------------------
// tb_teclado_atm
// Directed stimulus pushes the expected strobe (kind, value, cycle) into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT raises DIGITO_STB, MONTO_STB or DESBORDE. Expected timing follows the
// build option TECLADO_DEBOUNCE_EN (N samples) or the clean-input build.
// ---------------------------------------------------------------------------
module tb_teclado_atm;
    import teclado_pkg::*;

    localparam int N = 4;
`ifdef TECLADO_DEBOUNCE_EN
    localparam int NE = N;
`else
    localparam int NE = 1;
`endif

    localparam int K_NONE = 0;
    localparam int K_DIG  = 1;
    localparam int K_MON  = 2;
    localparam int K_DES  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    teclado_atm_if bus();

    teclado_atm #(.DEBOUNCE_CYCLES(N), .MAX_DIGITS(10)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int   nstb;
        int   kind;
        exp_t e;
        if (!rst) begin
            nstb = int'(bus.DIGITO_STB) + int'(bus.MONTO_STB) + int'(bus.DESBORDE);
            if (nstb != 0) begin
                if (nstb > 1) check("single_strobe", nstb, 1);
                kind = bus.DIGITO_STB ? K_DIG : (bus.MONTO_STB ? K_MON : K_DES);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", kind, e.kind);
                    check("strobe_cycle", cyc, e.cyc);
                    if (kind == K_DIG) check("DIGITO", 32'(bus.DIGITO), e.val);
                    if (kind == K_MON) check("MONTO", bus.MONTO, e.val);
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_strobe: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    // All tasks start and end on a negative clock edge.
    task automatic press(input logic [3:0] code, input int kind, input logic [31:0] val,
                         input int hold = 6, input int rel = 6);
        bus.TECLA        = code;
        bus.TECLA_VALIDA = 1'b1;
        if (kind != K_NONE) sb.push_back('{kind, val, cyc + NE});
        repeat (hold) @(negedge clk);
        bus.TECLA_VALIDA = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic level(input logic v, input int n);
        bus.TECLA_VALIDA = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus.TECLA        = 4'd0;
        bus.TECLA_VALIDA = 1'b0;
        bus.MODO_MONTO   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_DIGITO",     32'(bus.DIGITO), 0);
        check("rst_DIGITO_STB", 32'(bus.DIGITO_STB), 0);
        check("rst_MONTO",      bus.MONTO, 0);
        check("rst_MONTO_STB",  32'(bus.MONTO_STB), 0);
        check("rst_DESBORDE",   32'(bus.DESBORDE), 0);

        rst = 1'b0;
        repeat (6) @(negedge clk);

        // PIN mode digits 1..4
        for (int i = 1; i <= 4; i++) press(4'(i), K_DIG, 32'(i));

        // Bouncing press on key 7: high 2, low 1, high 2, low
        bus.TECLA = 4'd7;
`ifndef TECLADO_DEBOUNCE_EN
        sb.push_back('{K_DIG, 32'd7, cyc + 1});
`endif
        level(1'b1, 2);
        level(1'b0, 1);
`ifndef TECLADO_DEBOUNCE_EN
        sb.push_back('{K_DIG, 32'd7, cyc + 1});
`endif
        level(1'b1, 2);
        level(1'b0, 6);
        press(4'd7, K_DIG, 32'd7, 4, 6);

        // Non-digit keys are ignored in PIN mode
        press(TECLA_ENTER,  K_NONE, 0);
        press(TECLA_BORRAR, K_NONE, 0);
        press(4'hC,         K_NONE, 0);
        press(4'hF,         K_NONE, 0);
        check("pin_ignore_DIGITO", 32'(bus.DIGITO), 7);

        // Amount mode: 2,5,0,ENTER -> 250
        bus.MODO_MONTO = 1'b1;
        repeat (2) @(negedge clk);
        press(4'd2, K_NONE, 0);
        press(4'd5, K_NONE, 0);
        press(4'd0, K_NONE, 0);
        press(TECLA_ENTER, K_MON, 32'd250);
        // 7, BORRAR, ENTER -> nothing; amount held
        press(4'd7, K_NONE, 0);
        press(TECLA_BORRAR, K_NONE, 0);
        press(TECLA_ENTER, K_NONE, 0);
        check("monto_hold", bus.MONTO, 250);
        check("amount_no_DIGITO", 32'(bus.DIGITO), 7);

        // Overflow: 429496729 then 6 would be 2^32
        press(4'd4, K_NONE, 0);
        press(4'd2, K_NONE, 0);
        press(4'd9, K_NONE, 0);
        press(4'd4, K_NONE, 0);
        press(4'd9, K_NONE, 0);
        press(4'd6, K_NONE, 0);
        press(4'd7, K_NONE, 0);
        press(4'd2, K_NONE, 0);
        press(4'd9, K_NONE, 0);
        press(4'd6, K_DES, 0);
        press(TECLA_ENTER, K_MON, 32'd429496729);

        // Mode switch discards 33
        press(4'd3, K_NONE, 0);
        press(4'd3, K_NONE, 0);
        bus.MODO_MONTO = 1'b0;
        repeat (2) @(negedge clk);
        bus.MODO_MONTO = 1'b1;
        repeat (2) @(negedge clk);
        press(4'd8, K_NONE, 0);
        press(TECLA_ENTER, K_MON, 32'd8);

        // Digit limit: ten zeros fill the count, the eleventh is rejected
        for (int i = 0; i < 10; i++) press(4'd0, K_NONE, 0);
        press(4'd0, K_DES, 0);
        press(TECLA_ENTER, K_MON, 32'd0);

        // Reset with key 5 held
        bus.MODO_MONTO = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.TECLA        = 4'd5;
        bus.TECLA_VALIDA = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_MONTO",  bus.MONTO, 0);
        check("post_rst_DIGITO", 32'(bus.DIGITO), 0);
        level(1'b0, 6);
        press(4'd5, K_DIG, 32'd5);

        repeat (10) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe_end: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
